hazard_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32I core. Sits beside the fetch/decode/execute/memory/writeback stage registers.
- Generates stage stalls, flushes and operand-forwarding selects from decode/execute/memory/writeback hazard state.
- Tracks data-memory wait states with a watchdog and keeps stall/flush performance counters.

---
 rtl/hazard_controller_pkg.sv | 19 +
 rtl/hazard_controller_forward_unit.sv | 32 +++
 rtl/hazard_controller.sv | 149 ++++++++++++++
 tb/tb_hazard_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller:
// operand-forwarding selects, controller FSM encoding and a register-match helper.
package hazard_controller_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// Combinational ALU operand forwarding selects for both execute-stage sources.
// Zero latency; the memory stage result takes precedence over writeback.
module hazard_controller_forward_unit
  import hazard_controller_pkg::*;
(
  input  logic [4:0] rs1_e_i,
  input  logic [4:0] rs2_e_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] forward_a_o,
  output logic [1:0] forward_b_o
);

  function automatic logic [1:0] select_src(input logic [4:0] rs);
    logic [1:0] sel;
    sel = FWD_RF;
    if (reg_write_m_i && reg_match(rd_m_i, rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w_i && reg_match(rd_w_i, rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    forward_a_o = select_src(rs1_e_i);
    forward_b_o = select_src(rs2_e_i);
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencing for the 5-stage core, with a data-memory wait
// watchdog and stall/flush performance counters. Controls are same-cycle (Mealy).
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemTimeoutErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  logic       memwait;
  logic       loaduse;
  logic       stall_fd;
  logic       stall_em;
  logic       flush_d;
  logic       flush_e;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  hz_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  hazard_controller_forward_unit u_forward (
    .rs1_e_i       (RS1_E),
    .rs2_e_i       (RS2_E),
    .rd_m_i        (RD_M),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RD_W),
    .reg_write_w_i (RegWriteW),
    .forward_a_o   (fwd_a),
    .forward_b_o   (fwd_b)
  );

  assign memwait = MemReqM && !MemReadyM;
  assign loaduse = ResultSrcE && (reg_match(RD_E, RS1_D) || reg_match(RD_E, RS2_D));

  // A memory wait freezes E, so branch and load-use are re-judged once it ends.
  always_comb begin
    stall_fd = 1'b0;
    stall_em = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    if (memwait) begin
      stall_fd = 1'b1;
      stall_em = 1'b1;
    end else if (PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (loaduse) begin
      stall_fd = 1'b1;
      flush_e  = 1'b1;
    end
  end

  always_comb begin
    StallF        = stall_fd && !rst;
    StallD        = stall_fd && !rst;
    StallE        = stall_em && !rst;
    StallM        = stall_em && !rst;
    FlushD        = flush_d && !rst;
    FlushE        = flush_e && !rst;
    ForwardAE     = rst ? FWD_RF : fwd_a;
    ForwardBE     = rst ? FWD_RF : fwd_b;
    MemTimeoutErr = err_q;
    StallCount    = stall_cnt_q;
    FlushCount    = flush_cnt_q;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      RUN: begin
        if (memwait) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM || !MemReqM) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q != WCNT_MAX) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // The error latches on the edge where the wait count reaches the limit.
  always_comb begin
    err_d       = err_q || ((state_d == MEM_WAIT) && (wcnt_d == WCNT_MAX));
    stall_cnt_d = stall_cnt_q + CNT_W'(StallF);
    flush_cnt_d = flush_cnt_q + CNT_W'(FlushE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized checks of hazard_controller against a behavioural model.
module tb_hazard_controller;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  RS1_D = '0, RS2_D = '0, RS1_E = '0, RS2_E = '0, RD_E = '0, RD_M = '0, RD_W = '0;
  logic        ResultSrcE = 1'b0, PCSrcE = 1'b0, RegWriteM = 1'b0, MemReqM = 1'b0;
  logic        MemReadyM = 1'b0, RegWriteW = 1'b0;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeoutErr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCount, FlushCount;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: counts, length of the current memory-wait run, sticky error.
  int m_stalls = 0;
  int m_flushes = 0;
  int m_run = 0;
  bit m_err = 1'b0;

  hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RD_M(RD_M), .RegWriteM(RegWriteM),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .RD_W(RD_W), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemTimeoutErr(MemTimeoutErr), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rst) return 2'b00;
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  function automatic logic [5:0] exp_ctl();
    logic mw;
    logic lu;
    mw = MemReqM && !MemReadyM;
    lu = ResultSrcE && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
    if (rst) return 6'b000000;
    if (mw) return 6'b111100;
    if (PCSrcE) return 6'b000011;
    if (lu) return 6'b110001;
    return 6'b000000;
  endfunction

  task automatic check_now();
    chk("ctl", {26'd0, StallF, StallD, StallE, StallM, FlushD, FlushE}, {26'd0, exp_ctl()});
    chk("fwd_a", {30'd0, ForwardAE}, {30'd0, exp_fwd(RS1_E)});
    chk("fwd_b", {30'd0, ForwardBE}, {30'd0, exp_fwd(RS2_E)});
    chk("stall_cnt", StallCount, m_stalls);
    chk("flush_cnt", FlushCount, m_flushes);
    chk("timeout_err", {31'd0, MemTimeoutErr}, {31'd0, m_err});
  endtask

  task automatic model_reset();
    m_stalls = 0;
    m_flushes = 0;
    m_run = 0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    logic [5:0] c;
    c = exp_ctl();
    m_stalls += c[5];
    m_flushes += c[0];
    m_run = (MemReqM && !MemReadyM) ? m_run + 1 : 0;
    if (m_run >= TO) m_err = 1'b1;
  endtask

  task automatic cycle();
    #1;
    check_now();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    {RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W} = '0;
    {ResultSrcE, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW} = '0;
  endtask

  initial begin
    // Reset: drive conflicting hazards and check everything is forced to zero.
    @(negedge clk);
    RS1_E = 5; RD_M = 5; RegWriteM = 1; MemReqM = 1; PCSrcE = 1;
    #1;
    chk("rst_ctl", {26'd0, StallF, StallD, StallE, StallM, FlushD, FlushE}, 32'd0);
    chk("rst_fwd", {30'd0, ForwardAE}, 32'd0);
    chk("rst_cnt", StallCount, 32'd0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    cycle();

    // Forwarding priority: M beats W, then W alone, then x0 ignored.
    RS1_E = 5; RS2_E = 5; RD_M = 5; RegWriteM = 1; RD_W = 5; RegWriteW = 1;
    #1 chk("fwd_mem", {30'd0, ForwardAE}, 32'd2);
    cycle();
    RegWriteM = 0;
    #1 chk("fwd_wb", {30'd0, ForwardAE}, 32'd1);
    cycle();
    RegWriteM = 1; RS1_E = 0; RS2_E = 0; RD_M = 0; RD_W = 0;
    #1 chk("fwd_x0", {30'd0, ForwardBE}, 32'd0);
    cycle();
    idle();

    // Load-use bubble, then x0 destination produces no stall.
    ResultSrcE = 1; RD_E = 3; RS2_D = 3;
    cycle();
    idle();
    cycle();
    chk("lu_stalls", StallCount, 32'd1);
    chk("lu_flushes", FlushCount, 32'd1);
    ResultSrcE = 1; RD_E = 0; RS1_D = 0; RS2_D = 0;
    cycle();

    // Taken branch with a simultaneous load-use counts one flush.
    ResultSrcE = 1; RD_E = 7; RS1_D = 7; PCSrcE = 1;
    cycle();
    idle();
    cycle();
    chk("br_flushes", FlushCount, 32'd2);

    // Four wait cycles then ready.
    MemReqM = 1;
    repeat (4) cycle();
    MemReadyM = 1;
    #1 chk("mw_ready_drop", {31'd0, StallM}, 32'd0);
    cycle();
    idle();
    cycle();
    chk("mw_stalls", StallCount, 32'd5);
    chk("mw_no_err", {31'd0, MemTimeoutErr}, 32'd0);

    // Watchdog: twelve wait cycles; error appears after the eighth.
    MemReqM = 1;
    repeat (TO - 1) cycle();
    chk("to_early", {31'd0, MemTimeoutErr}, 32'd0);
    cycle();
    chk("to_set", {31'd0, MemTimeoutErr}, 32'd1);
    repeat (12 - TO) cycle();
    MemReadyM = 1;
    cycle();
    idle();
    cycle();
    chk("to_sticky", {31'd0, MemTimeoutErr}, 32'd1);

    // Asynchronous reset between edges in the middle of a wait.
    MemReqM = 1;
    repeat (3) cycle();
    #2 rst = 1'b1;
    model_reset();
    #1 check_now();
    chk("arst_err", {31'd0, MemTimeoutErr}, 32'd0);
    MemReqM = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    cycle();
    MemReqM = 1;
    repeat (TO - 1) cycle();
    idle();
    cycle();
    chk("arst_run", {31'd0, MemTimeoutErr}, 32'd0);

    // Randomized traffic over a small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      RS1_D = 5'($urandom_range(0, 7)); RS2_D = 5'($urandom_range(0, 7));
      RS1_E = 5'($urandom_range(0, 7)); RS2_E = 5'($urandom_range(0, 7));
      RD_E = 5'($urandom_range(0, 7)); RD_M = 5'($urandom_range(0, 7));
      RD_W = 5'($urandom_range(0, 7));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      ResultSrcE = ($urandom_range(0, 3) == 0);
      PCSrcE = ($urandom_range(0, 7) == 0);
      MemReqM = ($urandom_range(0, 2) != 0);
      MemReadyM = (i % 100 >= 80) ? 1'b0 : ($urandom_range(0, 2) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
